// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor: recovers line/frame position from HS/VS, locks, emits active pixels.
// Optional per-frame colour checksum output enabled by defining VGA_RX_CHECKSUM_EN.
module vga_rx_monitor #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACT_LEN   = 640,
   parameter int unsigned V_ACT_START = 35,
   parameter int unsigned V_ACT_LEN   = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        vga_clk,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   output logic        locked,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic        frame_start,
   output logic [9:0]  h_total_meas,
   output logic [9:0]  v_total_meas,
`ifdef VGA_RX_CHECKSUM_EN
   output logic [15:0] frame_sum,
`endif
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t      state_q, state_d;
   logic        vclk_q, vclk_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [3:0]  good_cnt_q, good_cnt_d;
   logic        frame_bad_q, frame_bad_d;
   logic        locked_q, locked_d, pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
   logic [9:0]  h_meas_q, h_meas_d, v_meas_q, v_meas_d;
   logic [7:0]  err_q, err_d;
`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] acc_q, acc_d, sum_q, sum_d, rgb_sum;
`endif

   logic        pix_en, hs_fall, vs_fall, line_bad, frame_err, bad_acc, in_act;
   logic [9:0]  idx, line, h_len, v_len;
   logic [3:0]  good_inc;

   assign pix_en   = vga_clk & ~vclk_q;
   assign hs_fall  = hs_prev_q & ~vga_hs;
   assign vs_fall  = vs_prev_q & ~vga_vs;
   assign h_len    = hcnt_q + 10'd1;
   assign v_len    = vcnt_q + 10'd1;
   assign good_inc = good_cnt_q + 4'd1;

   always_comb begin
      state_d       = state_q;
      vclk_d        = vga_clk;
      hs_prev_d     = hs_prev_q;
      vs_prev_d     = vs_prev_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      good_cnt_d    = good_cnt_q;
      frame_bad_d   = frame_bad_q;
      locked_d      = locked_q;
      pix_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_r_d       = pix_r_q;
      pix_g_d       = pix_g_q;
      pix_b_d       = pix_b_q;
      h_meas_d      = h_meas_q;
      v_meas_d      = v_meas_q;
      err_d         = err_q;
      idx           = hcnt_q;
      line          = vcnt_q;
      line_bad      = 1'b0;
      frame_err     = 1'b0;
      bad_acc       = frame_bad_q;
      in_act        = 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
      acc_d         = acc_q;
      sum_d         = sum_q;
      rgb_sum       = 16'(vga_r) + 16'(vga_g) + 16'(vga_b);
`endif
      if (pix_en) begin
         hs_prev_d = vga_hs;
         vs_prev_d = vga_vs;
         if (hs_fall) begin
            idx      = '0;
            h_meas_d = h_len;
            line_bad = (h_len != 10'(H_TOTAL));
            line     = (vcnt_q == '1) ? vcnt_q : v_len;
         end else begin
            idx      = (hcnt_q == '1) ? hcnt_q : h_len;
            // Saturation at 1023 means this transition happens only once per long line.
            line_bad = (hcnt_q == 10'd1022);
         end
         if (vs_fall) begin
            v_meas_d      = v_len;
            frame_err     = ~hs_fall | (v_len != 10'(V_TOTAL));
            line          = '0;
            frame_start_d = 1'b1;
         end
         hcnt_d  = idx;
         vcnt_d  = line;
         bad_acc = frame_bad_q | line_bad;

         unique case (state_q)
            SEARCH: begin
               if (vs_fall) begin
                  state_d     = MEASURE;
                  good_cnt_d  = '0;
                  frame_bad_d = 1'b0;
               end
            end
            MEASURE: begin
               frame_bad_d = bad_acc;
               if (vs_fall) begin
                  frame_bad_d = 1'b0;
                  if (!bad_acc && !frame_err) begin
                     good_cnt_d = good_inc;
                     if (good_inc == 4'(LOCK_FRAMES)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end else begin
                     good_cnt_d = '0;
                  end
               end
            end
            LOCKED: begin
               if (line_bad || (vs_fall && frame_err)) begin
                  err_d    = (err_q == '1) ? err_q : err_q + 8'd1;
                  locked_d = 1'b0;
                  state_d  = SEARCH;
               end
            end
            default: state_d = SEARCH;
         endcase

         in_act = locked_d
                  && (idx  >= 10'(H_ACT_START)) && (idx  < 10'(H_ACT_START + H_ACT_LEN))
                  && (line >= 10'(V_ACT_START)) && (line < 10'(V_ACT_START + V_ACT_LEN));
         if (in_act) begin
            pix_valid_d = 1'b1;
            pix_x_d     = idx - 10'(H_ACT_START);
            pix_y_d     = line - 10'(V_ACT_START);
            pix_r_d     = vga_r;
            pix_g_d     = vga_g;
            pix_b_d     = vga_b;
         end
`ifdef VGA_RX_CHECKSUM_EN
         if (vs_fall) begin
            if (locked_q) sum_d = acc_q;
            acc_d = in_act ? rgb_sum : '0;
         end else if (in_act) begin
            acc_d = acc_q + rgb_sum;
         end
`endif
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= SEARCH;
         vclk_q        <= 1'b0;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         good_cnt_q    <= '0;
         frame_bad_q   <= 1'b0;
         locked_q      <= 1'b0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_r_q       <= '0;
         pix_g_q       <= '0;
         pix_b_q       <= '0;
         h_meas_q      <= '0;
         v_meas_q      <= '0;
         err_q         <= '0;
`ifdef VGA_RX_CHECKSUM_EN
         acc_q         <= '0;
         sum_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         vclk_q        <= vclk_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         good_cnt_q    <= good_cnt_d;
         frame_bad_q   <= frame_bad_d;
         locked_q      <= locked_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_r_q       <= pix_r_d;
         pix_g_q       <= pix_g_d;
         pix_b_q       <= pix_b_d;
         h_meas_q      <= h_meas_d;
         v_meas_q      <= v_meas_d;
         err_q         <= err_d;
`ifdef VGA_RX_CHECKSUM_EN
         acc_q         <= acc_d;
         sum_q         <= sum_d;
`endif
      end
   end

   assign locked       = locked_q;
   assign pix_valid    = pix_valid_q;
   assign pix_x        = pix_x_q;
   assign pix_y        = pix_y_q;
   assign pix_r        = pix_r_q;
   assign pix_g        = pix_g_q;
   assign pix_b        = pix_b_q;
   assign frame_start  = frame_start_q;
   assign h_total_meas = h_meas_q;
   assign v_total_meas = v_meas_q;
   assign err_count    = err_q;
`ifdef VGA_RX_CHECKSUM_EN
   assign frame_sum    = sum_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor using a small timing geometry so full frames stay short.
// Honours VGA_RX_CHECKSUM_EN when defined for both DUT and bench.
module tb_vga_rx_monitor;

   localparam int unsigned HT = 8, VT = 6, HAS = 2, HAL = 4, VAS = 1, VAL = 3, LF = 2;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1, vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1;
   logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
   logic       locked, pix_valid, frame_start;
   logic [9:0] pix_x, pix_y, h_total_meas, v_total_meas;
   logic [7:0] pix_r, pix_g, pix_b, err_count;
`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] frame_sum;
`endif

   int checks = 0, failures = 0, valid_seen = 0;

   // Reference model: pixel run length since last HS fall, line number, and lock bookkeeping.
   int m_hs_prev, m_vs_prev, m_run, m_line, m_mode, m_good, m_fbad, m_locked, m_err;
   int m_valid, m_fs, m_px, m_py, m_r, m_g, m_b, m_htm, m_vtm, m_acc, m_sum;

   vga_rx_monitor #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
      .V_ACT_START(VAS), .V_ACT_LEN(VAL), .LOCK_FRAMES(LF)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .locked(locked), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .frame_start(frame_start), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
`ifdef VGA_RX_CHECKSUM_EN
      .frame_sum(frame_sum),
`endif
      .err_count(err_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hs_prev = 1; m_vs_prev = 1; m_run = 0; m_line = 0; m_mode = 0; m_good = 0;
      m_fbad = 0; m_locked = 0; m_err = 0; m_valid = 0; m_fs = 0; m_px = 0; m_py = 0;
      m_r = 0; m_g = 0; m_b = 0; m_htm = 0; m_vtm = 0; m_acc = 0; m_sum = 0;
   endtask

   // m_mode: 0 = hunting for a frame start, 1 = counting clean frames, 2 = locked
   task automatic model_step(input logic hs, input logic vs, input int r, input int g, input int b);
      int hf, vf, lbad, fbad, vold, lk0;
      hf = (m_hs_prev == 1) && !hs;
      vf = (m_vs_prev == 1) && !vs;
      m_hs_prev = hs; m_vs_prev = vs;
      vold = m_line; lk0 = m_locked; lbad = 0; fbad = 0;
      if (hf != 0) begin
         m_htm = m_run + 1;
         lbad = (m_run + 1 != HT);
         m_run = 0;
         m_line = (vold < 1023) ? vold + 1 : 1023;
      end else begin
         lbad = (m_run == 1022);
         if (m_run < 1023) m_run++;
      end
      if (vf != 0) begin
         m_vtm = vold + 1;
         fbad = (hf == 0) || (vold + 1 != VT);
         m_line = 0;
      end
      case (m_mode)
         0: if (vf != 0) begin m_mode = 1; m_good = 0; m_fbad = 0; end
         1: begin
            if (lbad != 0) m_fbad = 1;
            if (vf != 0) begin
               if (m_fbad == 0 && fbad == 0) m_good++; else m_good = 0;
               m_fbad = 0;
               if (m_good == LF) begin m_mode = 2; m_locked = 1; end
            end
         end
         default: if (lbad != 0 || (vf != 0 && fbad != 0)) begin
            if (m_err < 255) m_err++;
            m_locked = 0; m_mode = 0;
         end
      endcase
      m_fs = vf;
      m_valid = m_locked && m_run >= HAS && m_run < HAS + HAL && m_line >= VAS && m_line < VAS + VAL;
      if (m_valid != 0) begin
         m_px = m_run - HAS; m_py = m_line - VAS; m_r = r; m_g = g; m_b = b;
      end
      if (vf != 0) begin
         if (lk0 != 0) m_sum = m_acc;
         m_acc = (m_valid != 0) ? r + g + b : 0;
      end else if (m_valid != 0) begin
         m_acc = (m_acc + r + g + b) % 65536;
      end
   endtask

   task automatic check_outputs();
      chk("locked", locked, m_locked);
      chk("pix_valid", pix_valid, m_valid);
      chk("frame_start", frame_start, m_fs);
      chk("err_count", err_count, m_err);
      chk("h_total_meas", h_total_meas, m_htm % 1024);
      chk("v_total_meas", v_total_meas, m_vtm % 1024);
      chk("pix_x", pix_x, m_px);
      chk("pix_y", pix_y, m_py);
      chk("pix_rgb", {pix_r, pix_g, pix_b}, (m_r << 16) | (m_g << 8) | m_b);
`ifdef VGA_RX_CHECKSUM_EN
      chk("frame_sum", frame_sum, m_sum);
`endif
   endtask

   task automatic pixel(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
      @(negedge CLOCK_50);
      vga_clk = 1'b1; vga_hs = hs; vga_vs = vs; vga_r = r; vga_g = g; vga_b = b;
      @(negedge CLOCK_50);
      model_step(hs, vs, r, g, b);
      check_outputs();
      if (pix_valid === 1'b1) valid_seen++;
      vga_clk = 1'b0;
   endtask

   // HS low on the first pixel of each line, VS low for the whole first line.
   task automatic send_frame(input int lines, input int bad_line, input int bad_len, input bit ones);
      int len;
      for (int l = 0; l < lines; l++) begin
         len = (l == bad_line) ? bad_len : HT;
         for (int i = 0; i < len; i++) begin
            if (ones) pixel(i != 0, l != 0, 8'd1, 8'd1, 8'd1);
            else pixel(i != 0, l != 0, 8'($urandom), 8'($urandom), 8'($urandom));
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      check_outputs();
      chk("reset_h_meas", h_total_meas, 0);
      reset = 1'b0;

      send_frame(VT, -1, 0, 0);
      send_frame(VT, -1, 0, 0);
      chk("unlocked_before_3rd_vs", locked, 0);
      valid_seen = 0;
      send_frame(VT, -1, 0, 0);
      chk("locked_at_3rd_vs", locked, 1);
      chk("h_total_clean", h_total_meas, HT);
      chk("v_total_clean", v_total_meas, VT);
      chk("err_clean", err_count, 0);
      chk("valid_per_frame", valid_seen, HAL * VAL);

      send_frame(VT, 2, HT - 1, 0);
      chk("short_line_err", err_count, 1);
      chk("short_line_unlock", locked, 0);
      send_frame(VT, -1, 0, 0);
      send_frame(VT, -1, 0, 0);
      chk("relock_not_early", locked, 0);
      send_frame(VT, -1, 0, 0);
      chk("relock", locked, 1);

      send_frame(3, -1, 0, 0);
      @(negedge CLOCK_50);
      reset = 1'b1;
      @(negedge CLOCK_50);
      reset = 1'b0;
      model_reset();
      check_outputs();
      chk("midreset_locked", locked, 0);
      chk("midreset_v_meas", v_total_meas, 0);
      send_frame(VT, -1, 0, 0);
      send_frame(VT, -1, 0, 0);
      chk("midreset_not_early", locked, 0);
      send_frame(VT, -1, 0, 0);
      chk("midreset_relock", locked, 1);

      send_frame(VT, -1, 0, 1);
      send_frame(VT, -1, 0, 0);
`ifdef VGA_RX_CHECKSUM_EN
      chk("frame_sum_ones", frame_sum, 3 * HAL * VAL);
`endif

      for (int i = 0; i < 1000; i++) begin
         @(negedge CLOCK_50);
         vga_hs = 1'($urandom); vga_vs = 1'($urandom);
         chk("hold_valid", pix_valid, 0);
         chk("hold_fs", frame_start, 0);
         chk("hold_h_meas", h_total_meas, m_htm % 1024);
      end
      vga_hs = 1'b1; vga_vs = 1'b1;
      send_frame(VT, -1, 0, 0);
      chk("after_hold_locked", locked, 1);
      chk("after_hold_err", err_count, 0);

      send_frame(VT, 2, 1030, 0);
      chk("long_line_err", err_count, 1);
      chk("long_line_unlock", locked, 0);

      for (int k = 0; k < 260; k++) begin
         send_frame(2, 0, HT - 1, 0);
         send_frame(VT, -1, 0, 0);
         send_frame(VT, -1, 0, 0);
      end
      chk("err_saturated", err_count, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
